// File: rtl/mcd_irq_sched.sv
// ============================================================================
// mcd_irq_sched
// ----------------------------------------------------------------------------
// Sub-CPU interrupt source scheduler for the MCD mapper. It owns the IRQ mask
// register and the level-3 interval timer. It also turns one-cycle event
// strobes from the ASIC blocks into edge-safe request pulses for the sub-CPU
// interrupt controller.
//
// Parameters
//   PRESCALE    sub_sync ticks per timer tick (>= 2)
//   PULSE_LEN   clk_asic cycles each ireq pulse is held high (>= 2)
//
// Ports
//   clk_asic     in   1  block clock
//   rst_n        in   1  asynchronous active-low reset
//   sub_sync     in   1  sub-CPU clock-enable strobe, feeds the timer prescaler
//   reg_we       in   1  register write strobe
//   reg_sel      in   2  0=IMASK 1=TIMER 2=IFL2 3=STATUS
//   reg_wdata    in   8  register write data
//   reg_rdata    out  8  registered read data (1-cycle latency from reg_sel)
//   ev_gfx       in   1  level-1 event strobe
//   ev_cdd       in   1  level-4 event strobe
//   ev_cdc       in   1  level-5 event strobe
//   ev_subcode   in   1  level-6 event strobe
//   irq_pend_in  in   6  pending flags [6:1] from the interrupt controller
//   ireq         out  6  request pulses [6:1]
//   imsk         out  6  interrupt mask [6:1]
// ============================================================================
module mcd_irq_sched #(
    parameter int unsigned PRESCALE  = 384,
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic       clk_asic,
    input  logic       rst_n,
    input  logic       sub_sync,
    input  logic       reg_we,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    input  logic       ev_gfx,
    input  logic       ev_cdd,
    input  logic       ev_cdc,
    input  logic       ev_subcode,
    input  logic [6:1] irq_pend_in,
    output logic [6:1] ireq,
    output logic [6:1] imsk
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned CW = $clog2(PULSE_LEN);

    localparam logic [1:0] SEL_IMASK  = 2'd0;
    localparam logic [1:0] SEL_TIMER  = 2'd1;
    localparam logic [1:0] SEL_IFL2   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } pulse_state_e;

    // ------------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------------
    logic [6:1]    imsk_q, imsk_d;
    logic [7:0]    period_q, period_d;
    logic [7:0]    counter_q, counter_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [6:1]    ireq_q, ireq_d;

    logic          timer_wr;
    logic          imask_wr;
    logic          ifl2_ev;
    logic          timer_ev;
    logic [6:1]    ev_vec;
    logic [6:1]    busy;

    assign timer_wr = reg_we && (reg_sel == SEL_TIMER);
    assign imask_wr = reg_we && (reg_sel == SEL_IMASK);
    assign ifl2_ev  = reg_we && (reg_sel == SEL_IFL2) && reg_wdata[0];

    // ------------------------------------------------------------------------
    // Mask register
    // ------------------------------------------------------------------------
    always_comb begin
        imsk_d = imsk_q;
        if (imask_wr) begin
            imsk_d = reg_wdata[6:1];
        end
    end

    // ------------------------------------------------------------------------
    // Level-3 interval timer
    // A TIMER write takes priority over a tick expiring in the same cycle, so
    // that tick's event is lost and counting restarts from the new period.
    // ------------------------------------------------------------------------
    always_comb begin
        period_d  = period_q;
        counter_d = counter_q;
        presc_d   = presc_q;
        timer_ev  = 1'b0;
        if (timer_wr) begin
            period_d  = reg_wdata;
            counter_d = reg_wdata;
            presc_d   = '0;
        end else if ((period_q != 8'd0) && sub_sync) begin
            if (presc_q == PW'(PRESCALE - 1)) begin
                presc_d = '0;
                if (counter_q == 8'd1) begin
                    timer_ev  = 1'b1;
                    counter_d = period_q;
                end else begin
                    counter_d = counter_q - 8'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-level pulse generators
    // ------------------------------------------------------------------------
    assign ev_vec = {ev_subcode, ev_cdc, ev_cdd, timer_ev, ifl2_ev, ev_gfx};

    for (genvar g = 1; g <= 6; g++) begin : g_pulse
        pulse_state_e  state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          again_q, again_d;
        logic          high_d;

        // state register
        always_ff @(posedge clk_asic or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                again_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                again_q <= again_d;
            end
        end

        // next state
        // An event arriving in GAP with no queued request re-enters HIGH
        // directly; this is equivalent to setting the again flag and
        // consuming it on the same transition.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            again_d = again_q;
            case (state_q)
                ST_IDLE: begin
                    if (ev_vec[g]) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end
                end
                ST_HIGH: begin
                    if (ev_vec[g]) begin
                        again_d = 1'b1;
                    end
                    if (cnt_q == CW'(PULSE_LEN - 1)) begin
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (again_q || ev_vec[g]) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                        again_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    again_d = 1'b0;
                end
            endcase
        end

        // outputs: ireq is registered, so it is derived from the next state
        always_comb begin
            high_d = (state_d == ST_HIGH);
        end

        assign ireq_d[g] = high_d;
        assign busy[g]   = (state_q != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // Read data mux, registered
    // ------------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        case (reg_sel)
            SEL_IMASK:  rdata_d = {1'b0, imsk_q, 1'b0};
            SEL_TIMER:  rdata_d = period_q;
            SEL_IFL2:   rdata_d = {7'b0, busy[2]};
            SEL_STATUS: rdata_d = {1'b0, irq_pend_in, 1'b0};
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            imsk_q    <= '0;
            period_q  <= '0;
            counter_q <= '0;
            presc_q   <= '0;
            rdata_q   <= '0;
            ireq_q    <= '0;
        end else begin
            imsk_q    <= imsk_d;
            period_q  <= period_d;
            counter_q <= counter_d;
            presc_q   <= presc_d;
            rdata_q   <= rdata_d;
            ireq_q    <= ireq_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign ireq      = ireq_q;
    assign imsk      = imsk_q;

endmodule

// File: tb/tb_mcd_irq_sched.sv
// ============================================================================
// tb_mcd_irq_sched
// ----------------------------------------------------------------------------
// Self-checking bench for mcd_irq_sched. A reference model works in terms of
// scheduled pulse start cycles and raw sub_sync tick counts. Directed tasks
// cover the documented scenarios, and a randomized task then exercises every
// source together.
// ============================================================================
module tb_mcd_irq_sched;

    localparam int PRESCALE  = 4;
    localparam int PULSE_LEN = 4;

    logic       clk_asic;
    logic       rst_n;
    logic       sub_sync;
    logic       reg_we;
    logic [1:0] reg_sel;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       ev_gfx;
    logic       ev_cdd;
    logic       ev_cdc;
    logic       ev_subcode;
    logic [6:1] irq_pend_in;
    logic [6:1] ireq;
    logic [6:1] imsk;

    int n_cmp;
    int n_err;

    mcd_irq_sched #(
        .PRESCALE  (PRESCALE),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .clk_asic    (clk_asic),
        .rst_n       (rst_n),
        .sub_sync    (sub_sync),
        .reg_we      (reg_we),
        .reg_sel     (reg_sel),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .ev_gfx      (ev_gfx),
        .ev_cdd      (ev_cdd),
        .ev_cdc      (ev_cdc),
        .ev_subcode  (ev_subcode),
        .irq_pend_in (irq_pend_in),
        .ireq        (ireq),
        .imsk        (imsk)
    );

    initial clk_asic = 1'b0;
    always #5 clk_asic = ~clk_asic;

    // ------------------------------------------------------------------------
    // Reference model
    // Each level remembers the start cycle of its latest scheduled pulse and
    // of the one before it. A pulse started at s is high during s..s+L-1 and
    // leaves the level busy through s+L. An event at cycle t starts a pulse at
    // t+1 when the level is free. Otherwise it queues one pulse right after
    // the current busy window, unless one is already queued.
    // ------------------------------------------------------------------------
    int         cyc;
    int         latest_s [1:6];
    int         prev_s   [1:6];
    logic [7:0] m_period;
    int         m_ticks;
    logic [6:1] m_imsk;
    logic [7:0] m_rdata;
    logic [6:1] m_ireq;
    logic [6:1] m_ev;
    logic       m_tev;
    logic       m_busy2;

    function automatic bit in_high(int s, int c);
        return (c >= s) && (c <= s + PULSE_LEN - 1);
    endfunction

    function automatic bit in_busy(int s, int c);
        return (c >= s) && (c <= s + PULSE_LEN);
    endfunction

    initial cyc = 0;

    always @(posedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            m_period = '0;
            m_ticks  = 0;
            m_imsk   = '0;
            m_rdata  = '0;
            m_ireq   = '0;
            for (int i = 1; i <= 6; i++) begin
                latest_s[i] = -1000;
                prev_s[i]   = -1000;
            end
        end else begin
            // read data reflects the state before this edge
            m_busy2 = in_busy(latest_s[2], cyc) || in_busy(prev_s[2], cyc);
            case (reg_sel)
                2'd0:    m_rdata = {1'b0, m_imsk, 1'b0};
                2'd1:    m_rdata = m_period;
                2'd2:    m_rdata = {7'b0, m_busy2};
                default: m_rdata = {1'b0, irq_pend_in, 1'b0};
            endcase

            // timer: one event every period*PRESCALE sub_sync ticks
            m_tev = 1'b0;
            if (reg_we && reg_sel == 2'd1) begin
                m_period = reg_wdata;
                m_ticks  = 0;
            end else if (m_period != 0 && sub_sync) begin
                m_ticks++;
                if (m_ticks == int'(m_period) * PRESCALE) begin
                    m_tev   = 1'b1;
                    m_ticks = 0;
                end
            end

            if (reg_we && reg_sel == 2'd0) m_imsk = reg_wdata[6:1];

            m_ev = {ev_subcode, ev_cdc, ev_cdd, m_tev,
                    reg_we && (reg_sel == 2'd2) && reg_wdata[0], ev_gfx};
            for (int lv = 1; lv <= 6; lv++) begin
                if (m_ev[lv]) begin
                    if (latest_s[lv] > cyc) begin
                        // one pulse already queued: drop
                    end else if (cyc > latest_s[lv] + PULSE_LEN) begin
                        prev_s[lv]   = latest_s[lv];
                        latest_s[lv] = cyc + 1;
                    end else begin
                        prev_s[lv]   = latest_s[lv];
                        latest_s[lv] = latest_s[lv] + PULSE_LEN + 1;
                    end
                end
            end

            cyc++;
            for (int lv = 1; lv <= 6; lv++) begin
                m_ireq[lv] = in_high(latest_s[lv], cyc) || in_high(prev_s[lv], cyc);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic idle_inputs();
        reg_we      = 1'b0;
        reg_sel     = 2'd0;
        reg_wdata   = '0;
        ev_gfx      = 1'b0;
        ev_cdd      = 1'b0;
        ev_cdc      = 1'b0;
        ev_subcode  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        sub_sync    = 1'b0;
        irq_pend_in = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk_asic);
        n_cmp++;
        if (ireq !== 6'h00) begin
            n_err++;
            $display("FAIL reset_ireq: got %h expected 00", ireq);
        end
        n_cmp++;
        if (imsk !== 6'h00) begin
            n_err++;
            $display("FAIL reset_imsk: got %h expected 00", imsk);
        end
        n_cmp++;
        if (reg_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_rdata: got %h expected 00", reg_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk_asic);
    endtask

    task automatic test_imask();
        reg_we    = 1'b1;
        reg_sel   = 2'd0;
        reg_wdata = 8'h7E;
        @(negedge clk_asic);
        reg_we = 1'b0;
        n_cmp++;
        if (imsk !== 6'h3F) begin
            n_err++;
            $display("FAIL imask_write: got %h expected 3f", imsk);
        end
        @(negedge clk_asic);
        n_cmp++;
        if (reg_rdata !== 8'h7E) begin
            n_err++;
            $display("FAIL imask_read: got %h expected 7e", reg_rdata);
        end
        n_cmp++;
        if (reg_rdata !== m_rdata) begin
            n_err++;
            $display("FAIL imask_read_model: got %h expected %h", reg_rdata, m_rdata);
        end
    endtask

    task automatic test_timer();
        int   rises[$];
        logic prev3;
        sub_sync  = 1'b1;
        reg_we    = 1'b1;
        reg_sel   = 2'd1;
        reg_wdata = 8'd3;
        prev3     = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk_asic);
            reg_we = 1'b0;
            if (ireq[3] && !prev3) rises.push_back(k);
            prev3 = ireq[3];
            n_cmp++;
            if (ireq !== m_ireq) begin
                n_err++;
                $display("FAIL timer_ireq k=%0d: got %h expected %h", k, ireq, m_ireq);
            end
        end
        n_cmp++;
        if (rises.size() != 3) begin
            n_err++;
            $display("FAIL timer_rise_count: got %0d expected 3", rises.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (rises[i] != 12 * (i + 1)) begin
                    n_err++;
                    $display("FAIL timer_rise_%0d: got %0d expected %0d", i, rises[i], 12 * (i + 1));
                end
            end
        end
        // stop the timer
        reg_we    = 1'b1;
        reg_wdata = 8'd0;
        rises.delete();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_asic);
            reg_we = 1'b0;
            if (ireq[3] && !prev3) rises.push_back(k);
            prev3 = ireq[3];
        end
        n_cmp++;
        if (rises.size() != 0) begin
            n_err++;
            $display("FAIL timer_stopped: got %0d rises expected 0", rises.size());
        end
        sub_sync = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp_pat;
        exp_pat = 14'b00000111101111;
        ev_gfx  = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk_asic);
            if (k == 1) ev_gfx = 1'b0;
            if (k == 0) ev_gfx = 1'b1;
            n_cmp++;
            if (ireq[1] !== exp_pat[k]) begin
                n_err++;
                $display("FAIL b2b_ireq1 k=%0d: got %b expected %b", k, ireq[1], exp_pat[k]);
            end
            n_cmp++;
            if (ireq !== m_ireq) begin
                n_err++;
                $display("FAIL b2b_model k=%0d: got %h expected %h", k, ireq, m_ireq);
            end
        end
        ev_gfx = 1'b0;
    endtask

    task automatic test_ifl2();
        logic [9:0] exp_ireq2;
        logic [9:0] exp_rd;
        exp_ireq2 = 10'b0000001111;
        exp_rd    = 10'b0000111110;
        reg_we    = 1'b1;
        reg_sel   = 2'd2;
        reg_wdata = 8'h01;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk_asic);
            reg_we = 1'b0;
            n_cmp++;
            if (ireq[2] !== exp_ireq2[k]) begin
                n_err++;
                $display("FAIL ifl2_ireq2 k=%0d: got %b expected %b", k, ireq[2], exp_ireq2[k]);
            end
            n_cmp++;
            if (reg_rdata !== {7'b0, exp_rd[k]}) begin
                n_err++;
                $display("FAIL ifl2_read k=%0d: got %h expected %h", k, reg_rdata, {7'b0, exp_rd[k]});
            end
        end
        // wdata[0]=0 raises nothing
        reg_we    = 1'b1;
        reg_wdata = 8'hFE;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk_asic);
            reg_we = 1'b0;
            n_cmp++;
            if (ireq[2] !== 1'b0) begin
                n_err++;
                $display("FAIL ifl2_zero k=%0d: got %b expected 0", k, ireq[2]);
            end
        end
    endtask

    task automatic test_timer_collide();
        int   rises[$];
        logic prev3;
        sub_sync  = 1'b1;
        reg_we    = 1'b1;
        reg_sel   = 2'd1;
        reg_wdata = 8'd2;
        prev3     = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk_asic);
            reg_we = 1'b0;
            if (k == 7) begin
                // lands on the edge where the period-2 countdown expires
                reg_we    = 1'b1;
                reg_wdata = 8'd5;
            end
            if (ireq[3] && !prev3) rises.push_back(k);
            prev3 = ireq[3];
            n_cmp++;
            if (ireq !== m_ireq) begin
                n_err++;
                $display("FAIL collide_ireq k=%0d: got %h expected %h", k, ireq, m_ireq);
            end
        end
        n_cmp++;
        if (rises.size() != 1) begin
            n_err++;
            $display("FAIL collide_rise_count: got %0d expected 1", rises.size());
        end else begin
            n_cmp++;
            if (rises[0] != 28) begin
                n_err++;
                $display("FAIL collide_rise_at: got %0d expected 28", rises[0]);
            end
        end
        n_cmp++;
        if (reg_rdata !== 8'd5) begin
            n_err++;
            $display("FAIL collide_period_read: got %h expected 05", reg_rdata);
        end
        reg_we    = 1'b1;
        reg_wdata = 8'd0;
        @(negedge clk_asic);
        reg_we   = 1'b0;
        sub_sync = 1'b0;
        repeat (6) @(negedge clk_asic);
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk_asic);
            n_cmp++;
            if (ireq !== m_ireq) begin
                n_err++;
                $display("FAIL rand_ireq k=%0d: got %h expected %h", k, ireq, m_ireq);
            end
            n_cmp++;
            if (imsk !== m_imsk) begin
                n_err++;
                $display("FAIL rand_imsk k=%0d: got %h expected %h", k, imsk, m_imsk);
            end
            n_cmp++;
            if (reg_rdata !== m_rdata) begin
                n_err++;
                $display("FAIL rand_rdata k=%0d: got %h expected %h", k, reg_rdata, m_rdata);
            end
            ev_gfx      = ($urandom_range(0, 5) == 0);
            ev_cdd      = ($urandom_range(0, 5) == 0);
            ev_cdc      = ($urandom_range(0, 7) == 0);
            ev_subcode  = ($urandom_range(0, 3) == 0);
            sub_sync    = ($urandom_range(0, 1) == 1);
            irq_pend_in = 6'($urandom);
            reg_sel     = 2'($urandom);
            reg_we      = ($urandom_range(0, 5) == 0);
            reg_wdata   = 8'($urandom);
            if (reg_sel == 2'd1) reg_wdata = 8'($urandom_range(0, 4));
        end
        idle_inputs();
        sub_sync = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        reg_we    = 1'b1;
        reg_sel   = 2'd0;
        reg_wdata = 8'h5A;
        @(negedge clk_asic);
        reg_we = 1'b0;
        ev_cdd = 1'b1;
        @(negedge clk_asic);
        ev_cdd = 1'b0;
        @(negedge clk_asic);
        n_cmp++;
        if (ireq[4] !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pulse_on: got %b expected 1", ireq[4]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ireq !== 6'h00) begin
            n_err++;
            $display("FAIL midrst_ireq: got %h expected 00", ireq);
        end
        n_cmp++;
        if (imsk !== 6'h00) begin
            n_err++;
            $display("FAIL midrst_imsk: got %h expected 00", imsk);
        end
        n_cmp++;
        if (reg_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_rdata: got %h expected 00", reg_rdata);
        end
        repeat (2) @(negedge clk_asic);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk_asic);
            n_cmp++;
            if (ireq !== 6'h00) begin
                n_err++;
                $display("FAIL midrst_after: got %h expected 00", ireq);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_imask();
        test_timer();
        test_back_to_back();
        test_ifl2();
        test_timer_collide();
        test_random();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
